// File: rtl/alu_issue_pkg.sv
// ============================================================================
// Module : alu_issue_pkg
// Brief  : Shared encodings for the ALU issue stage (operand selects, control
//          bundle layout, issue-buffer state).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_issue_pkg;

  localparam int CTRL_LEN = 9;

  // Control bundle layout {OP,LR,AL,is_or,is_xor,is_and,is_cmp,is_sign,is_shift}
  localparam int CTRL_OP_BIT       = 8;
  localparam int CTRL_LR_BIT       = 7;
  localparam int CTRL_AL_BIT       = 6;
  localparam int CTRL_IS_OR_BIT    = 5;
  localparam int CTRL_IS_XOR_BIT   = 4;
  localparam int CTRL_IS_AND_BIT   = 3;
  localparam int CTRL_IS_CMP_BIT   = 2;
  localparam int CTRL_IS_SIGN_BIT  = 1;
  localparam int CTRL_IS_SHIFT_BIT = 0;

  localparam logic       SRC1_RS1  = 1'b0;
  localparam logic       SRC1_PC   = 1'b1;
  localparam logic [1:0] SRC2_RS2  = 2'd0;
  localparam logic [1:0] SRC2_IMM  = 2'd1;
  localparam logic [1:0] SRC2_FOUR = 2'd2;
  localparam logic [1:0] SRC2_ZERO = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_issue_opsel.sv
// ============================================================================
// Module : alu_issue_opsel
// Brief  : Writeback bypass on rs1/rs2 followed by the NUM_A / NUM_B muxes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_opsel
  import alu_issue_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] pc,
  input  logic [DATA_LEN-1:0] rs1_val,
  input  logic [DATA_LEN-1:0] rs2_val,
  input  logic [DATA_LEN-1:0] imm,
  input  logic [4:0]          rs1_idx,
  input  logic [4:0]          rs2_idx,
  input  logic                src1_sel,
  input  logic [1:0]          src2_sel,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic [DATA_LEN-1:0] wb_data,
  output logic [DATA_LEN-1:0] num_a,
  output logic [DATA_LEN-1:0] num_b
);

  logic [DATA_LEN-1:0] w_rs1;
  logic [DATA_LEN-1:0] w_rs2;

  // x0 is never bypassed: it reads as whatever decode supplied.
  assign w_rs1 = (wb_valid && (wb_rd == rs1_idx) && (rs1_idx != 5'd0)) ? wb_data : rs1_val;
  assign w_rs2 = (wb_valid && (wb_rd == rs2_idx) && (rs2_idx != 5'd0)) ? wb_data : rs2_val;

  assign num_a = (src1_sel == SRC1_PC) ? pc : w_rs1;

  always_comb begin
    num_b = w_rs2;
    unique case (src2_sel)
      SRC2_RS2:  num_b = w_rs2;
      SRC2_IMM:  num_b = imm;
      SRC2_FOUR: num_b = DATA_LEN'(4);
      SRC2_ZERO: num_b = '0;
      default:   num_b = w_rs2;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// ============================================================================
// Module : alu_issue
// Brief  : Two-entry (head + skid) issue buffer between decode and the ALU,
//          resolving operands and writeback bypass at capture time.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int CTRL_LEN = alu_issue_pkg::CTRL_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_pc,
  input  logic [DATA_LEN-1:0] in_rs1_val,
  input  logic [DATA_LEN-1:0] in_rs2_val,
  input  logic [DATA_LEN-1:0] in_imm,
  input  logic [4:0]          in_rs1_idx,
  input  logic [4:0]          in_rs2_idx,
  input  logic                in_src1_sel,
  input  logic [1:0]          in_src2_sel,
  input  logic [CTRL_LEN-1:0] in_ctrl,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic [DATA_LEN-1:0] wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_num_a,
  output logic [DATA_LEN-1:0] out_num_b,
  output logic [CTRL_LEN-1:0] out_ctrl,
  output logic [DATA_LEN-1:0] out_pc
);

  issue_state_t        r_state;
  issue_state_t        w_state_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [DATA_LEN-1:0] r_head_a, r_head_b, r_head_pc;
  logic [CTRL_LEN-1:0] r_head_ctrl;
  logic [DATA_LEN-1:0] r_skid_a, r_skid_b, r_skid_pc;
  logic [CTRL_LEN-1:0] r_skid_ctrl;
  logic [DATA_LEN-1:0] w_num_a, w_num_b;
  logic                w_push, w_pop;
  logic                w_load_head, w_load_skid, w_skid_to_head;

  alu_issue_opsel #(.DATA_LEN(DATA_LEN)) u_opsel (
    .pc       (in_pc),
    .rs1_val  (in_rs1_val),
    .rs2_val  (in_rs2_val),
    .imm      (in_imm),
    .rs1_idx  (in_rs1_idx),
    .rs2_idx  (in_rs2_idx),
    .src1_sel (in_src1_sel),
    .src2_sel (in_src2_sel),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .num_a    (w_num_a),
    .num_b    (w_num_b)
  );

  assign w_push = in_valid && r_in_ready && !flush;
  assign w_pop  = r_out_valid && out_ready;

  // New entry goes straight to head when head is empty or leaving this cycle.
  assign w_load_head    = w_push && ((r_state == ST_EMPTY) || ((r_state == ST_ONE) && w_pop));
  assign w_load_skid    = w_push && (r_state == ST_ONE) && !w_pop;
  assign w_skid_to_head = w_pop && (r_state == ST_TWO);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_TWO;
        else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (w_pop) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
    if (flush) w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head_a    <= '0;
      r_head_b    <= '0;
      r_head_pc   <= '0;
      r_head_ctrl <= '0;
      r_skid_a    <= '0;
      r_skid_b    <= '0;
      r_skid_pc   <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_TWO);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      if (w_load_head) begin
        r_head_a    <= w_num_a;
        r_head_b    <= w_num_b;
        r_head_pc   <= in_pc;
        r_head_ctrl <= in_ctrl;
      end else if (w_skid_to_head) begin
        r_head_a    <= r_skid_a;
        r_head_b    <= r_skid_b;
        r_head_pc   <= r_skid_pc;
        r_head_ctrl <= r_skid_ctrl;
      end
      if (w_load_skid) begin
        r_skid_a    <= w_num_a;
        r_skid_b    <= w_num_b;
        r_skid_pc   <= in_pc;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_num_a = r_head_a;
  assign out_num_b = r_head_b;
  assign out_pc    = r_head_pc;
  assign out_ctrl  = r_head_ctrl;

endmodule

`default_nettype wire
